// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_pkg
// Purpose  : Shared definitions for the WS2812 SFR pixel driver: SFR address
//            map, control-register bit positions, FSM state encoding, default
//            timing constants and the brightness scaling helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // SFR address map (write-only)
    localparam logic [7:0] SFR_IDX    = 8'hC0;
    localparam logic [7:0] SFR_G      = 8'hC1;
    localparam logic [7:0] SFR_R      = 8'hC2;
    localparam logic [7:0] SFR_B      = 8'hC3;
    localparam logic [7:0] SFR_CTRL   = 8'hC4;
    localparam logic [7:0] SFR_BRIGHT = 8'hC5;

    // Control register bit positions
    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IDX_CLR_BIT = 1;

    // Default chain size and timing (50 MHz clock)
    localparam int DEF_NUM_LEDS = 8;
    localparam int DEF_T0H      = 20;
    localparam int DEF_T1H      = 40;
    localparam int DEF_T_BIT    = 62;
    localparam int DEF_T_RESET  = 2600;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_LATCH = 3'd4
    } ws2812_state_e;

    // (c * (b + 1)) >> 8 : 8x9-bit product, result truncated to 8 bits.
    // b = 0xFF multiplies by 256, so the channel passes through unchanged.
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = {9'd0, c} * ({9'd0, b} + 17'd1);
        return 8'(prod >> 8);
    endfunction

    function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
        return {scale_channel(w[23:16], b), scale_channel(w[15:8], b), scale_channel(w[7:0], b)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_tx.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_bit_tx
// Purpose  : WS2812 bit serialiser. Shifts a 24-bit GRB word out MSB first,
//            each bit T_BIT cycles long with a T1H/T0H high phase. A load on
//            the final cycle of a word starts the next word with no gap.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            i_load, i_word   - load strobe and 24-bit word to send
//            o_din            - registered serial line
//            o_high_last      - last cycle of the current bit's high phase
//            o_bit_end        - last cycle of the current bit
//            o_word_done      - last cycle of the 24th bit
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T0H   = DEF_T0H,
    parameter int T1H   = DEF_T1H,
    parameter int T_BIT = DEF_T_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [23:0] i_word,
    output logic        o_din,
    output logic        o_high_last,
    output logic        o_bit_end,
    output logic        o_word_done
);

    localparam int CNT_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    localparam logic [CNT_W-1:0] c_T0H      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] c_T1H      = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(T_BIT - 1);

    logic [23:0]      r_shift, w_shift_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]       r_bit, w_bit_nxt;
    logic             r_active, w_active_nxt;
    logic             r_din, w_din_nxt;
    logic [CNT_W-1:0] w_thresh;
    logic             w_high_last, w_bit_end, w_word_done;

    always_comb begin
        w_thresh     = r_shift[23] ? c_T1H : c_T0H;
        w_high_last  = r_active && (r_cnt == (w_thresh - CNT_W'(1)));
        w_bit_end    = r_active && (r_cnt == c_BIT_LAST);
        w_word_done  = w_bit_end && (r_bit == 5'd23);

        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_active_nxt = r_active;

        if (i_load) begin
            w_shift_nxt  = i_word;
            w_cnt_nxt    = '0;
            w_bit_nxt    = 5'd0;
            w_active_nxt = 1'b1;
        end else if (w_bit_end) begin
            w_cnt_nxt = '0;
            if (r_bit == 5'd23) begin
                w_active_nxt = 1'b0;
            end else begin
                w_bit_nxt   = r_bit + 5'd1;
                w_shift_nxt = {r_shift[22:0], 1'b0};
            end
        end else if (r_active) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        // Line level is computed from next state so din is a clean flop output.
        w_din_nxt = w_active_nxt && (w_cnt_nxt < (w_shift_nxt[23] ? c_T1H : c_T0H));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_bit    <= 5'd0;
            r_active <= 1'b0;
            r_din    <= 1'b0;
        end else begin
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_active <= w_active_nxt;
            r_din    <= w_din_nxt;
        end
    end

    assign o_din       = r_din;
    assign o_high_last = w_high_last;
    assign o_bit_end   = w_bit_end;
    assign o_word_done = w_word_done;

endmodule
`default_nettype wire

// File: rtl/ws2812_sfr_driver.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_sfr_driver
// Purpose  : 8051 SFR-mapped WS2812 chain driver. Holds the GRB pixel buffer,
//            decodes SFR writes, sequences a frame of NUM_LEDS pixels through
//            ws2812_bit_tx and appends the T_RESET latch gap.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            sfr_addr            - SFR address (0xC0..0xC5 decoded)
//            controller_data_in  - SFR write data
//            sfr_wr              - one-cycle write strobe
//            din                 - serial data to the first LED
//            busy                - frame in progress (incl. latch gap)
// Options  : WS2812_BRIGHT_EN    - define to enable the 0xC5 brightness scaler
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_sfr_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T_RESET  = DEF_T_RESET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] controller_data_in,
    input  logic       sfr_wr,
    output logic       din,
    output logic       busy
);

    localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int LATCH_W = (T_RESET > 1) ? $clog2(T_RESET) : 1;
    localparam logic [7:0]         c_LAST_PIX   = 8'(NUM_LEDS - 1);
    localparam logic [LATCH_W-1:0] c_LATCH_LAST = LATCH_W'(T_RESET - 1);

    ws2812_state_e      r_state, w_state_nxt;
    logic [7:0]         r_idx, r_g, r_r;
    logic [7:0]         r_pix, w_pix_nxt;
    logic [LATCH_W-1:0] r_latch_cnt, w_latch_nxt;
    logic [23:0]        r_buf [NUM_LEDS];

    logic               w_wr_en, w_start, w_tx_load;
    logic [IDX_W-1:0]   w_fetch_idx;
    logic [23:0]        w_fetch_raw, w_fetch_word;
    logic               w_high_last, w_bit_end, w_word_done;

    // The whole register map is frozen while a frame is running.
    assign w_wr_en = sfr_wr && (r_state == ST_IDLE);
    assign w_start = w_wr_en && (sfr_addr == SFR_CTRL) && controller_data_in[CTRL_START_BIT];
    assign busy    = (r_state != ST_IDLE);

    // ---------------------------------------------------------------- SFR regs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= 8'd0;
            r_g   <= 8'd0;
            r_r   <= 8'd0;
        end else if (w_wr_en) begin
            case (sfr_addr)
                SFR_IDX: begin
                    if ({1'b0, controller_data_in} < 9'(NUM_LEDS)) r_idx <= controller_data_in;
                end
                SFR_G: r_g <= controller_data_in;
                SFR_R: r_r <= controller_data_in;
                SFR_B: r_idx <= (r_idx == c_LAST_PIX) ? 8'd0 : r_idx + 8'd1;
                SFR_CTRL: begin
                    if (controller_data_in[CTRL_IDX_CLR_BIT]) r_idx <= 8'd0;
                end
                SFR_BRIGHT: ;   // brightness register is handled below
                default: ;
            endcase
        end
    end

    // Pixel buffer: deliberately not reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en && (sfr_addr == SFR_B)) begin
            r_buf[r_idx[IDX_W-1:0]] <= {r_g, r_r, controller_data_in};
        end
    end

    assign w_fetch_raw = r_buf[w_fetch_idx];

`ifdef WS2812_BRIGHT_EN
    logic [7:0] r_bright;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bright <= 8'hFF;
        end else if (w_wr_en && (sfr_addr == SFR_BRIGHT)) begin
            r_bright <= controller_data_in;
        end
    end

    assign w_fetch_word = scale_word(w_fetch_raw, r_bright);
`else
    assign w_fetch_word = w_fetch_raw;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pix       <= 8'd0;
            r_latch_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix       <= w_pix_nxt;
            r_latch_cnt <= w_latch_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pix_nxt   = r_pix;
        w_latch_nxt = '0;
        w_tx_load   = 1'b0;
        w_fetch_idx = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_tx_load   = 1'b1;
                w_pix_nxt   = 8'd0;
                w_state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_high_last) w_state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (w_word_done) begin
                    if (r_pix == c_LAST_PIX) begin
                        w_state_nxt = ST_LATCH;
                    end else begin
                        // Prefetch on the final cycle of the word: the next
                        // pixel's first bit starts on the following edge.
                        w_tx_load   = 1'b1;
                        w_fetch_idx = r_pix[IDX_W-1:0] + IDX_W'(1);
                        w_pix_nxt   = r_pix + 8'd1;
                        w_state_nxt = ST_HIGH;
                    end
                end else if (w_bit_end) begin
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_LATCH: begin
                if (r_latch_cnt == c_LATCH_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_latch_nxt = r_latch_cnt + LATCH_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    ws2812_bit_tx #(
        .T0H   (T0H),
        .T1H   (T1H),
        .T_BIT (T_BIT)
    ) u_bit_tx (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_tx_load),
        .i_word      (w_fetch_word),
        .o_din       (din),
        .o_high_last (w_high_last),
        .o_bit_end   (w_bit_end),
        .o_word_done (w_word_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_ws2812_sfr_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_sfr_driver
// Purpose  : Directed self-checking bench for ws2812_sfr_driver. Frames are
//            captured from din as high/low run lengths and decoded back into
//            GRB words, then compared with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_sfr_driver;

    localparam int NUM_LEDS  = 8;
    localparam int T0H       = 20;
    localparam int T1H       = 40;
    localparam int T_BIT     = 62;
    localparam int T_RESET   = 2600;
    localparam int FRAME_LEN = 1 + NUM_LEDS * 24 * T_BIT + T_RESET;  // 14505
    localparam int GUARD     = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sfr_addr;
    logic [7:0] controller_data_in;
    logic       sfr_wr;
    logic       din;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int          cap_hi[$];
    int          cap_lo[$];
    int          cap_busy, cap_lead, cap_terr;
    logic        cap_timeout;
    logic [23:0] cap_px [NUM_LEDS];

    always #5 clk = ~clk;

    ws2812_sfr_driver #(
        .NUM_LEDS (NUM_LEDS),
        .T0H      (T0H),
        .T1H      (T1H),
        .T_BIT    (T_BIT),
        .T_RESET  (T_RESET)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .sfr_addr           (sfr_addr),
        .controller_data_in (controller_data_in),
        .sfr_wr             (sfr_wr),
        .din                (din),
        .busy               (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        sfr_addr           = a;
        controller_data_in = d;
        sfr_wr             = 1'b1;
        @(negedge clk);
        sfr_wr             = 1'b0;
    endtask

    // Samples once per cycle on the falling edge while busy is high,
    // recording high and low run lengths of din, then decodes pixels.
    task automatic capture_frame();
        int   hi_run, lo_run, guard, n;
        logic seen_hi, prev;
        cap_hi.delete();
        cap_lo.delete();
        cap_busy = 0; cap_lead = 0; cap_terr = 0;
        hi_run = 0; lo_run = 0; guard = 0;
        seen_hi = 1'b0; prev = 1'b0;
        while (busy === 1'b1 && guard < GUARD) begin
            cap_busy++;
            if (din === 1'b1) begin
                if (!prev && seen_hi) begin
                    cap_lo.push_back(lo_run);
                    lo_run = 0;
                end
                seen_hi = 1'b1;
                hi_run++;
            end else begin
                if (prev) begin
                    cap_hi.push_back(hi_run);
                    hi_run = 0;
                end
                if (seen_hi) lo_run++;
                else cap_lead++;
            end
            prev = (din === 1'b1);
            @(negedge clk);
            guard++;
        end
        if (seen_hi) cap_lo.push_back(lo_run);
        cap_timeout = (guard >= GUARD);

        for (int p = 0; p < NUM_LEDS; p++) cap_px[p] = 24'h0;
        n = cap_hi.size();
        for (int k = 0; k < n && k < NUM_LEDS * 24; k++) begin
            cap_px[k / 24] = {cap_px[k / 24][22:0], (cap_hi[k] == T1H)};
        end
        for (int k = 0; k < n; k++) begin
            if (cap_hi[k] != T0H && cap_hi[k] != T1H) cap_terr++;
            if (k < cap_lo.size()) begin
                if (k < n - 1) begin
                    if (cap_hi[k] + cap_lo[k] != T_BIT) cap_terr++;
                end else if (cap_lo[k] != T_BIT - cap_hi[k] + T_RESET) begin
                    cap_terr++;
                end
            end else begin
                cap_terr++;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_timeout"}, {31'd0, cap_timeout}, 32'd0);
        check({tag, "_busy_len"}, cap_busy, FRAME_LEN);
        check({tag, "_nbits"}, cap_hi.size(), NUM_LEDS * 24);
        check({tag, "_timing_err"}, cap_terr, 0);
    endtask

    initial begin
        int idle_bad;

        rst                = 1'b1;
        sfr_wr             = 1'b0;
        sfr_addr           = 8'h00;
        controller_data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_din", {31'd0, din}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Idle for 100 cycles: line must stay low and not busy.
        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (din !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        check("idle_100", idle_bad, 0);

        // Single pixel, default timing.
        sfr_write(8'hC0, 8'h00);
        sfr_write(8'hC1, 8'h80);
        sfr_write(8'hC2, 8'h00);
        sfr_write(8'hC3, 8'h01);
        sfr_write(8'hC4, 8'h01);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_din", {31'd0, din}, 32'd0);
        capture_frame();
        check_frame("f1");
        check("f1_lead", cap_lead, 1);
        check("f1_px0", cap_px[0], 24'h800001);
        check("f1_hi0", cap_hi[0], 40);
        check("f1_lo0", cap_lo[0], 22);
        check("f1_hi1", cap_hi[1], 20);
        check("f1_lo1", cap_lo[1], 42);
        check("f1_hi23", cap_hi[23], 40);

        // Eight pixels without index writes, ninth B write wraps to pixel 0.
        sfr_write(8'hC4, 8'h02);
        for (int p = 0; p < NUM_LEDS; p++) begin
            sfr_write(8'hC1, 8'h10 + 8'(p));
            sfr_write(8'hC2, 8'h20 + 8'(p));
            sfr_write(8'hC3, 8'h30 + 8'(p));
        end
        sfr_write(8'hC1, 8'hAA);
        sfr_write(8'hC2, 8'h55);
        sfr_write(8'hC3, 8'hC3);
        sfr_write(8'hC4, 8'h01);
        capture_frame();
        check_frame("f2");
        check("f2_px0_wrap", cap_px[0], 24'hAA55C3);
        for (int p = 1; p < NUM_LEDS; p++) begin
            check($sformatf("f2_px%0d", p), cap_px[p], {8'h10 + 8'(p), 8'h20 + 8'(p), 8'h30 + 8'(p)});
        end

        // Start and pixel writes while busy are ignored.
        sfr_write(8'hC4, 8'h01);
        fork
            capture_frame();
            begin
                repeat (100) @(negedge clk);
                sfr_write(8'hC4, 8'h01);
                sfr_write(8'hC0, 8'h03);
                sfr_write(8'hC1, 8'hFF);
                sfr_write(8'hC2, 8'hFF);
                sfr_write(8'hC3, 8'hFF);
                sfr_write(8'hC4, 8'h03);
            end
        join
        check_frame("f3");
        check("f3_px3", cap_px[3], 24'h132333);
        check("f3_px0", cap_px[0], 24'hAA55C3);
        repeat (5) @(negedge clk);
        check("f3_no_restart", {31'd0, busy}, 32'd0);

        // Reset mid-frame abandons the frame without a latch gap.
        sfr_write(8'hC4, 8'h01);
        repeat (4999) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_din", {31'd0, din}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_still_idle", {31'd0, busy}, 32'd0);

        // Out-of-range index is ignored; the B write lands in pixel 2.
        sfr_write(8'hC0, 8'h02);
        sfr_write(8'hC0, 8'h08);
        sfr_write(8'hC1, 8'h01);
        sfr_write(8'hC2, 8'h02);
        sfr_write(8'hC3, 8'h03);
        sfr_write(8'hC4, 8'h01);
        capture_frame();
        check_frame("f4");
        check("f4_px0", cap_px[0], 24'hAA55C3);
        check("f4_px1", cap_px[1], 24'h112131);
        check("f4_px2_idx_bound", cap_px[2], 24'h010203);

`ifdef WS2812_BRIGHT_EN
        sfr_write(8'hC0, 8'h00);
        sfr_write(8'hC5, 8'h7F);
        sfr_write(8'hC1, 8'h80);
        sfr_write(8'hC2, 8'h00);
        sfr_write(8'hC3, 8'h00);
        sfr_write(8'hC4, 8'h01);
        capture_frame();
        check_frame("f5");
        check("f5_bright_px0", cap_px[0], 24'h400000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
